// File: rtl/sb_cfg_mux_bank.sv
// Routing-mux bank with a double-buffered configuration chain.
// Bits shift into a shadow chain, and a commit copies the whole chain into the active selects in one edge.
module sb_cfg_mux_bank #(
  parameter  int NUM_MUX  = 4,
  parameter  int MUX_SIZE = 6,
  localparam int SEL_W    = $clog2(MUX_SIZE),
  localparam int TOTAL    = NUM_MUX * SEL_W,
  localparam int CNT_W    = $clog2(TOTAL + 1)
) (
  input  logic                        prog_clk,
  input  logic                        prog_reset_n,
  input  logic                        ccff_head,
  input  logic                        ccff_shift_en,
  input  logic                        ccff_commit,
  input  logic [NUM_MUX*MUX_SIZE-1:0] mux_in,
  output logic [NUM_MUX-1:0]          mux_out,
  output logic [NUM_MUX-1:0]          mux_oor,
  output logic                        ccff_tail,
  output logic [CNT_W-1:0]            cfg_count,
  output logic                        cfg_full,
  output logic                        active_valid,
  output logic                        cfg_err
);

  localparam logic [CNT_W-1:0] COUNT_MAX    = CNT_W'(TOTAL);
  localparam logic [SEL_W:0]   MUX_SIZE_EXT = (SEL_W + 1)'(MUX_SIZE);

  logic [TOTAL-1:0] shadow;
  logic [TOTAL-1:0] active;
  logic             commit_ok;

  assign cfg_full  = (cfg_count == COUNT_MAX);
  assign commit_ok = ccff_commit & cfg_full;
  assign ccff_tail = shadow[TOTAL-1];

  // The commit samples the pre-shift shadow, so a same-cycle shift never leaks into active.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shadow       <= '0;
      active       <= '0;
      cfg_count    <= '0;
      active_valid <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      if (ccff_shift_en) begin
        shadow <= (shadow << 1) | TOTAL'(ccff_head);
      end
      if (commit_ok) begin
        active       <= shadow;
        active_valid <= 1'b1;
        cfg_count    <= ccff_shift_en ? CNT_W'(1) : '0;
      end else if (ccff_shift_en && !cfg_full) begin
        cfg_count <= cfg_count + CNT_W'(1);
      end
      if (ccff_commit && !cfg_full) begin
        cfg_err <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_MUX; k++) begin : g_mux
    logic [SEL_W-1:0] sel;
    logic             pick;

    assign sel        = active[k*SEL_W +: SEL_W];
    assign mux_oor[k] = ({1'b0, sel} >= MUX_SIZE_EXT);

    // Only in-range selects can match, so an out-of-range select leaves pick at 0.
    always_comb begin
      pick = 1'b0;
      for (int i = 0; i < MUX_SIZE; i++) begin
        if (sel == SEL_W'(i)) begin
          pick = mux_in[k*MUX_SIZE + i];
        end
      end
    end

    assign mux_out[k] = active_valid & ~mux_oor[k] & pick;
  end

endmodule

// File: tb/tb_sb_cfg_mux_bank.sv
// Scoreboarded bench for sb_cfg_mux_bank: expectations are queued with each stimulus step
// and compared one cycle later, 1 time unit after the active clock edge.
module tb_sb_cfg_mux_bank;

  localparam int NUM_MUX  = 4;
  localparam int MUX_SIZE = 6;
  localparam int TOTAL    = 12;
  localparam int CNT_W    = 4;

  // Shadow images, bit 11 is shifted first: A = mux3=1 mux2=0 mux1=5 mux0=2, B = mux0=7, others 0
  localparam logic [TOTAL-1:0] CFG_A = 12'b001_000_101_010;
  localparam logic [TOTAL-1:0] CFG_B = 12'b000_000_000_111;

  localparam int F_OUT = 0, F_OOR = 1, F_TAIL = 2, F_CNT = 3, F_FULL = 4, F_VALID = 5, F_ERR = 6;

  logic                        prog_clk = 1'b0;
  logic                        prog_reset_n = 1'b0;
  logic                        ccff_head = 1'b0;
  logic                        ccff_shift_en = 1'b0;
  logic                        ccff_commit = 1'b0;
  logic [NUM_MUX*MUX_SIZE-1:0] mux_in = '0;
  logic [NUM_MUX-1:0]          mux_out;
  logic [NUM_MUX-1:0]          mux_oor;
  logic                        ccff_tail;
  logic [CNT_W-1:0]            cfg_count;
  logic                        cfg_full;
  logic                        active_valid;
  logic                        cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          field;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  sb_cfg_mux_bank #(.NUM_MUX(NUM_MUX), .MUX_SIZE(MUX_SIZE)) dut (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_commit  (ccff_commit),
    .mux_in       (mux_in),
    .mux_out      (mux_out),
    .mux_oor      (mux_oor),
    .ccff_tail    (ccff_tail),
    .cfg_count    (cfg_count),
    .cfg_full     (cfg_full),
    .active_valid (active_valid),
    .cfg_err      (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int f);
    case (f)
      F_OUT:   return 32'(mux_out);
      F_OOR:   return 32'(mux_oor);
      F_TAIL:  return 32'(ccff_tail);
      F_CNT:   return 32'(cfg_count);
      F_FULL:  return 32'(cfg_full);
      F_VALID: return 32'(active_valid);
      default: return 32'(cfg_err);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int field, input logic [31:0] val);
    exp_t e;
    e.tag   = tag;
    e.field = field;
    e.val   = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.field), e.val);
    end
  endtask

  task automatic expect_all_zero(input string tag);
    expect_val({tag, "_out"},   F_OUT,   0);
    expect_val({tag, "_oor"},   F_OOR,   0);
    expect_val({tag, "_tail"},  F_TAIL,  0);
    expect_val({tag, "_cnt"},   F_CNT,   0);
    expect_val({tag, "_full"},  F_FULL,  0);
    expect_val({tag, "_valid"}, F_VALID, 0);
    expect_val({tag, "_err"},   F_ERR,   0);
  endtask

  task automatic cycle(input logic sh, input logic hd, input logic cm);
    ccff_shift_en = sh;
    ccff_head     = hd;
    ccff_commit   = cm;
    @(posedge prog_clk);
    #1;
    ccff_shift_en = 1'b0;
    ccff_commit   = 1'b0;
  endtask

  task automatic shift_word(input logic [TOTAL-1:0] w);
    for (int i = TOTAL - 1; i >= 0; i--) cycle(1'b1, w[i], 1'b0);
  endtask

  task automatic set_route_a();
    mux_in     = '0;
    mux_in[2]  = 1'b1;
    mux_in[11] = 1'b1;
    mux_in[12] = 1'b1;
    mux_in[19] = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with random control activity and all mux inputs high
    prog_reset_n = 1'b0;
    mux_in = '1;
    for (int r = 0; r < 4; r++) begin
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      expect_all_zero("reset");
      drain();
    end
    prog_reset_n = 1'b1;

    // Program configuration A; routing stays off until the first commit
    shift_word(CFG_A);
    expect_val("prog_cnt",     F_CNT,   12);
    expect_val("prog_full",    F_FULL,  1);
    expect_val("prog_valid",   F_VALID, 0);
    expect_val("prog_out_off", F_OUT,   0);
    drain();
    set_route_a();
    cycle(1'b0, 1'b0, 1'b1);
    expect_val("commit_out",   F_OUT,   4'b1111);
    expect_val("commit_oor",   F_OOR,   4'b0000);
    expect_val("commit_valid", F_VALID, 1);
    expect_val("commit_cnt",   F_CNT,   0);
    expect_val("commit_full",  F_FULL,  0);
    expect_val("commit_err",   F_ERR,   0);
    drain();
    mux_in = '0;
    mux_in[11] = 1'b1;
    #1;
    expect_val("route_mux1_only", F_OUT, 4'b0010);
    drain();
    set_route_a();

    // Shift in configuration B: readback of A on the tail, a rejected commit after 7 bits
    for (int k = 0; k < TOTAL; k++) begin
      if (k == 7) begin
        cycle(1'b0, 1'b0, 1'b1);
        expect_val("reject_err",   F_ERR,   1);
        expect_val("reject_cnt",   F_CNT,   7);
        expect_val("reject_out",   F_OUT,   4'b1111);
        expect_val("reject_valid", F_VALID, 1);
        drain();
      end
      expect_val($sformatf("readback_tail_%0d", k), F_TAIL, 32'(CFG_A[TOTAL-1-k]));
      expect_val($sformatf("hold_out_%0d", k),      F_OUT,  4'b1111);
      drain();
      cycle(1'b1, CFG_B[TOTAL-1-k], 1'b0);
    end
    expect_val("reprog_cnt",  F_CNT,  12);
    expect_val("reprog_full", F_FULL, 1);
    expect_val("reprog_out",  F_OUT,  4'b1111);
    drain();

    // Commit B with all inputs high: mux0 select 7 is out of range
    mux_in = '1;
    cycle(1'b0, 1'b0, 1'b1);
    expect_val("oor_flags", F_OOR, 4'b0001);
    expect_val("oor_out",   F_OUT, 4'b1110);
    expect_val("oor_cnt",   F_CNT, 0);
    expect_val("oor_err",   F_ERR, 1);
    drain();

    // Saturation, then simultaneous shift and commit
    set_route_a();
    cycle(1'b1, 1'b1, 1'b0);
    shift_word(CFG_A);
    expect_val("sat_cnt",  F_CNT,  12);
    expect_val("sat_full", F_FULL, 1);
    drain();
    cycle(1'b1, 1'b1, 1'b1);
    expect_val("simul_out",  F_OUT,  4'b1111);
    expect_val("simul_oor",  F_OOR,  4'b0000);
    expect_val("simul_cnt",  F_CNT,  1);
    expect_val("simul_full", F_FULL, 0);
    expect_val("simul_tail", F_TAIL, 0);
    drain();

    // Reset asserted mid-cycle after 5 more shifts
    for (int s = 0; s < 5; s++) cycle(1'b1, 1'b1, 1'b0);
    expect_val("pre_reset_cnt", F_CNT, 6);
    drain();
    ccff_shift_en = 1'b1;
    ccff_head = 1'b1;
    #2;
    prog_reset_n = 1'b0;
    #1;
    expect_all_zero("async_reset");
    drain();
    @(posedge prog_clk);
    #1;
    ccff_shift_en = 1'b0;
    prog_reset_n = 1'b1;
    expect_all_zero("after_reset");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_cfg_mux_bank.md
# sb_cfg_mux_bank

Parametrised routing-mux bank with a double-buffered configuration chain, used as the building block of next-generation switch blocks. Configuration bits shift through a shadow chain on `prog_clk` while the routing stays on the last committed configuration. A commit pulse loads the whole shadow chain into the active registers at once, so routing never glitches during reprogramming. The block also counts shifted bits, rejects incomplete commits, and flags out-of-range mux selects.

## Interface
- `NUM_MUX`, 4, number of routing muxes in the bank.
- `MUX_SIZE`, 6, inputs per mux (≥2).
- `SEL_W`, derived `$clog2(MUX_SIZE)`, select bits per mux; not overridable.
- `TOTAL`, derived `NUM_MUX*SEL_W`, configuration chain length.
- `CNT_W`, derived `$clog2(TOTAL+1)`, width of the bit counter.

Ports:
- `prog_clk`  in  1  configuration clock; the only clock.
- `prog_reset_n`  in  1  reset; asynchronous, active-low.
- `ccff_head`  in  1  serial configuration data in.
- `ccff_shift_en`  in  1  shift the shadow chain by one bit this cycle.
- `ccff_commit`  in  1  request a shadow→active transfer.
- `mux_in`  in  NUM_MUX*MUX_SIZE  mux k input i at bit `k*MUX_SIZE+i`.
- `mux_out`  out  NUM_MUX  routed outputs.
- `mux_oor`  out  NUM_MUX  active select of mux k ≥ MUX_SIZE.
- `ccff_tail`  out  1  serial data out (chain / readback).
- `cfg_count`  out  CNT_W  bits shifted since the last accepted commit.
- `cfg_full`  out  1  `cfg_count == TOTAL`.
- `active_valid`  out  1  at least one commit accepted since reset.
- `cfg_err`  out  1  sticky error flag.

## Operation
- Shadow chain `shadow[0:TOTAL-1]`.
  - On a `ccff_shift_en` edge: `shadow[0] <= ccff_head`, `shadow[i] <= shadow[i-1]`.
  - `ccff_tail = shadow[TOTAL-1]`. The output is a register bit, not a comb path from `ccff_head`.
- Bit mapping: mux k select bit j (j=0 is LSB) is register bit `k*SEL_W+j`. The first bit shifted in lands at mux NUM_MUX-1, MSB.
- Counter:
  - Increments on `ccff_shift_en`.
  - Saturates at TOTAL; further shifts still move data.
- Commit:
  - Accepted when `ccff_commit` is high and `cfg_full` is high:
    - `active <= shadow` (value before any same-cycle shift).
    - `active_valid <= 1`.
    - `cfg_count <= ccff_shift_en ? 1 : 0`.
  - Rejected when `ccff_commit` is high and `cfg_full` is low:
    - `active` is unchanged.
    - `cfg_err <= 1`.
    - The counter behaves as if no commit occurred.
- `cfg_err` is cleared only by reset.
- Shadow contents are retained after a commit. Further shifts read the previous configuration out on `ccff_tail`, which is the readback path.
- Mux k:
  - `mux_oor[k] = (sel_k >= MUX_SIZE)`.
  - `mux_out[k] = mux_in[k*MUX_SIZE+sel_k]` when `active_valid` is high and `mux_oor[k]` is low; otherwise 0.

## Timing
- Reset (asynchronous assert, synchronous to `prog_clk` on deassert) clears:
  - shadow and active registers to 0,
  - `cfg_count` = 0, `cfg_full` = 0, `active_valid` = 0, `cfg_err` = 0.
- Resulting output values during reset: `ccff_tail` = 0, `mux_out` = 0, `mux_oor` = 0.
- Reset asserted mid-shift or mid-commit takes effect immediately. The partial configuration is discarded.
- Shift latency: a bit on `ccff_head` appears on `ccff_tail` TOTAL edges later.
- Commit latency: `mux_out` and `mux_oor` reflect the new configuration combinationally after the accepting edge.
- `mux_out` is combinational from `mux_in` with no register; its only state is the active selects.
- Shift and commit in the same cycle: the commit samples the pre-shift shadow, and the shift proceeds.

## Test plan
- Reset check: assert `prog_reset_n`=0 with random inputs -> every output is 0; `mux_out`=4'b0000 even with `mux_in` all ones.
- Program and commit:
  - Stimulus: shift stream 0,0,1, 0,0,0, 1,0,1, 0,1,0, giving selects mux3=1, mux2=0, mux1=5, mux0=2. Then commit. Drive `mux_in` bits 2, 11, 12, 19 to 1 and all others to 0.
  - Required: `cfg_full`=1 before the commit; `mux_out`=4'b1111, `active_valid`=1 and `cfg_count`=0 after it.
- Incomplete commit: after the above, shift 7 bits and commit -> `cfg_err`=1, `cfg_count`=7, `mux_out` unchanged at 4'b1111.
- Out-of-range select: program mux0 sel=7 and commit with `mux_in` all ones -> `mux_oor`=4'b0001, `mux_out[0]`=0.
- Glitch-free reprogram with readback:
  - Stimulus: from the configuration in scenario 2, shift 12 new bits.
  - Required: `mux_out` holds its old value until the commit; `ccff_tail` emits 0,0,1,0,0,0,1,0,1,0,1,0 in order.
- Simultaneous events:
  - Full chain, shift=1 and commit=1 in the same cycle -> active takes the pre-shift shadow, `cfg_count`=1.
  - Reset asserted after 5 shifts -> `cfg_count`=0 immediately.
